// File: rtl/fir_decim_avg.sv
// Block-averaging decimator (sum of DECIM samples >> log2(DECIM)) feeding a small result FIFO.
// Define FIR_DECIM_ROUND_EN for round-half-up results; truncation otherwise.
module fir_decim_avg #(
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    input  logic        clr_ovf,
    output logic        ovf,
    output logic [7:0]  drop_cnt
);
    localparam int SH = $clog2(DECIM);
    localparam int AW = 16 + SH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] acc_reg, acc_next;
    logic [SH-1:0] ph_reg, ph_next;
    logic [AW-1:0] sum;
    logic [AW-1:0] rounded;
    logic [15:0]   res;
    logic          push;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          full, pop, wr_en, drop;

    // The accumulator is wide enough that DECIM full-scale samples (plus the rounding
    // offset) never wrap, so the shifted result always fits in 16 bits.
    assign sum = acc_reg + AW'(din);
`ifdef FIR_DECIM_ROUND_EN
    assign rounded = sum + AW'(DECIM / 2);
`else
    assign rounded = sum;
`endif
    assign res  = rounded[AW-1:SH];
    assign push = din_valid && (ph_reg == SH'(DECIM - 1));

    always_comb begin
        acc_next = acc_reg;
        ph_next  = ph_reg;
        if (din_valid) begin
            if (push) begin
                acc_next = '0;
                ph_next  = '0;
            end else begin
                acc_next = sum;
                ph_next  = ph_reg + SH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            ph_reg  <= '0;
        end else begin
            acc_reg <= acc_next;
            ph_reg  <= ph_next;
        end
    end

    // A push into a full FIFO survives only if the head is popped on the same edge.
    assign dout_valid = (count_reg != '0);
    assign full       = (count_reg == CW'(FIFO_DEPTH));
    assign pop        = dout_valid && dout_ready;
    assign wr_en      = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign count_next = count_reg + CW'(wr_en) - CW'(pop);
    assign dout       = dout_valid ? mem[rd_ptr_reg] : 16'd0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
        end
    end

    // A drop on the same edge as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= 8'd0;
        end
    end
endmodule

// File: tb/tb_fir_decim_avg.sv
// Randomised and directed bench for fir_decim_avg against a queue-based reference model.
module tb_fir_decim_avg;
    localparam int DECIM      = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef FIR_DECIM_ROUND_EN
    localparam int RND     = DECIM / 2;
    localparam int EXP_RND = 2;
`else
    localparam int RND     = 0;
    localparam int EXP_RND = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = 16'd0;
    logic        din_valid = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int failures = 0;

    int blk[$];
    int fq[$];
    int m_ovf = 0;
    int m_drop = 0;

    fir_decim_avg #(.DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .clr_ovf(clr_ovf), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic int exp_dout();
        return (fq.size() > 0) ? fq[0] : 0;
    endfunction

    function automatic int exp_valid();
        return (fq.size() > 0) ? 1 : 0;
    endfunction

    // Drive one cycle, advance the model at the edge, return 1 time unit after it.
    task automatic cycle(input logic v, input int d, input logic r, input logic c);
        int  s;
        bit  pop;
        bit  drp;
        din_valid  = v;
        din        = d[15:0];
        dout_ready = r;
        clr_ovf    = c;
        @(posedge clk);
        if (rst) begin
            blk.delete();
            fq.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            pop = (fq.size() > 0) && r;
            drp = 1'b0;
            if (pop) void'(fq.pop_front());
            if (v) begin
                blk.push_back(int'(d[15:0]));
                if (blk.size() == DECIM) begin
                    s = 0;
                    foreach (blk[i]) s += blk[i];
                    blk.delete();
                    if (fq.size() < FIFO_DEPTH) fq.push_back((s + RND) / DECIM);
                    else drp = 1'b1;
                end
            end
            if (drp) begin
                m_ovf  = 1;
                m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (c) begin
                m_ovf  = 0;
                m_drop = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
        checks++; if (dout !== 16'd0) begin failures++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_basic();
        cycle(1'b1, 100, 1'b1, 1'b0);
        cycle(1'b1, 200, 1'b1, 1'b0);
        cycle(1'b1, 300, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", dout_valid); end
        cycle(1'b1, 400, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", dout_valid); end
        checks++; if (dout !== 16'd250) begin failures++; $display("FAIL basic_dout: got %0d expected 250", dout); end
        cycle(1'b0, 0, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle: got %b expected 0", dout_valid); end
    endtask

    task automatic test_rounding();
        cycle(1'b1, 1, 1'b1, 1'b0);
        cycle(1'b1, 2, 1'b1, 1'b0);
        cycle(1'b1, 2, 1'b1, 1'b0);
        cycle(1'b1, 2, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'(EXP_RND)) begin
            failures++; $display("FAIL rounding: got valid=%b dout=%0d expected valid=1 dout=%0d", dout_valid, dout, EXP_RND);
        end
        cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < DECIM; i++) cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'hFFFF) begin
            failures++; $display("FAIL full_scale: got valid=%b dout=%h expected valid=1 dout=ffff", dout_valid, dout);
        end
        cycle(1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5 * DECIM; i++) begin
            cycle(1'b1, 16, 1'b0, 1'b0);
            if (i == 4 * DECIM - 1) begin
                checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL bp_ovf_early: got %b expected 0", ovf); end
            end
        end
        checks++; if (dout_valid !== 1'b1 || dout !== 16'd16) begin
            failures++; $display("FAIL bp_head: got valid=%b dout=%0d expected valid=1 dout=16", dout_valid, dout);
        end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf: got %b expected 1", ovf); end
        checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL bp_drop: got %0d expected 1", drop_cnt); end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            checks++; if (dout_valid !== 1'b1 || dout !== 16'd16) begin
                failures++; $display("FAIL bp_drain_%0d: got valid=%b dout=%0d expected valid=1 dout=16", k, dout_valid, dout);
            end
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: got %b expected 0", dout_valid); end
        cycle(1'b0, 0, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
            failures++; $display("FAIL bp_clear: got ovf=%b drop=%0d expected 0/0", ovf, drop_cnt);
        end
    endtask

    task automatic test_gaps_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 100 * i, 1'b1, 1'b0);
            if (i == 4) begin
                checks++; if (dout_valid !== 1'b1 || dout !== 16'd250) begin
                    failures++; $display("FAIL gaps_dout: got valid=%b dout=%0d expected valid=1 dout=250", dout_valid, dout);
                end
            end
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        cycle(1'b1, 50, 1'b1, 1'b0);
        cycle(1'b1, 50, 1'b1, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 0, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL midrst_early: got %b expected 0", dout_valid); end
        cycle(1'b1, 8, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b1 || dout !== 16'd8) begin
            failures++; $display("FAIL midrst_dout: got valid=%b dout=%0d expected valid=1 dout=8", dout_valid, dout);
        end
        cycle(1'b0, 0, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL midrst_single: got %b expected 0", dout_valid); end
    endtask

    task automatic test_clear_collision();
        for (int i = 0; i < (FIFO_DEPTH + 3) * DECIM; i++) cycle(1'b1, $urandom_range(0, 65535), 1'b0, 1'b0);
        checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd3) begin
            failures++; $display("FAIL coll_pre: got ovf=%b drop=%0d expected 1/3", ovf, drop_cnt);
        end
        for (int i = 0; i < DECIM - 1; i++) cycle(1'b1, $urandom_range(0, 65535), 1'b0, 1'b0);
        cycle(1'b1, $urandom_range(0, 65535), 1'b0, 1'b1);
        checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin
            failures++; $display("FAIL coll_drop_wins: got ovf=%b drop=%0d expected 1/1", ovf, drop_cnt);
        end
        cycle(1'b0, 0, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin
            failures++; $display("FAIL coll_clear: got ovf=%b drop=%0d expected 0/0", ovf, drop_cnt);
        end
        for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
            checks++; if (dout_valid !== 1'(exp_valid()) || dout !== 16'(exp_dout())) begin
                failures++; $display("FAIL coll_drain_%0d: got valid=%b dout=%0d expected valid=%0d dout=%0d", k, dout_valid, dout, exp_valid(), exp_dout());
            end
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < (FIFO_DEPTH + 270) * DECIM; i++) cycle(1'b1, $urandom_range(0, 65535), 1'b0, 1'b0);
        checks++; if (drop_cnt !== 8'd255 || ovf !== 1'b1) begin
            failures++; $display("FAIL sat_drop: got ovf=%b drop=%0d expected 1/255", ovf, drop_cnt);
        end
        checks++; if (dout !== 16'(exp_dout())) begin
            failures++; $display("FAIL sat_head: got %0d expected %0d", dout, exp_dout());
        end
        cycle(1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < FIFO_DEPTH; k++) cycle(1'b0, 0, 1'b1, 1'b0);
        checks++; if (dout_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            failures++; $display("FAIL sat_clear: got valid=%b drop=%0d expected 0/0", dout_valid, drop_cnt);
        end
    endtask

    task automatic test_random();
        int  rdy_pct;
        logic v, r, c;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) rdy_pct = $urandom_range(10, 100);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(1, 100) <= rdy_pct);
            c = ($urandom_range(0, 63) == 0);
            cycle(v, $urandom_range(0, 65535), r, c);
            checks++; if (dout_valid !== 1'(exp_valid())) begin
                failures++; $display("FAIL rand_valid@%0d: got %b expected %0d", i, dout_valid, exp_valid());
            end
            checks++; if (dout !== 16'(exp_dout())) begin
                failures++; $display("FAIL rand_dout@%0d: got %0d expected %0d", i, dout, exp_dout());
            end
            checks++; if (ovf !== 1'(m_ovf)) begin
                failures++; $display("FAIL rand_ovf@%0d: got %b expected %0d", i, ovf, m_ovf);
            end
            checks++; if (drop_cnt !== 8'(m_drop)) begin
                failures++; $display("FAIL rand_drop@%0d: got %0d expected %0d", i, drop_cnt, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_full_scale();
        test_backpressure();
        test_gaps_reset();
        test_clear_collision();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
